// File: rtl/bpu_pkg.sv
// Shared types and sizing for the branch predict unit.
// The top module's BPU_GSHARE_EN build macro uses the GHR_BITS width defined here.
package bpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BHT_ENTRIES = 64;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned GHR_BITS    = 6;
  localparam int unsigned BHT_IDX_W   = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int unsigned BTB_TAG_W   = XLEN - BTB_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      target;
    logic                 is_jump;
  } btb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic [XLEN-1:0]      target;
    logic [BHT_IDX_W-1:0] bht_idx;
  } bpu_pipe_t;

  // Saturating 2-bit counter step.
  function automatic bht_ctr_e ctr_next(input bht_ctr_e ctr, input logic taken);
    bht_ctr_e nxt;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      default: nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline <-> branch predictor signal bundle (fetch lookup, stage control, E resolution).
interface branch_predict_unit_if;
  import bpu_pkg::*;

  logic [XLEN-1:0] PCF;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic            BranchE;
  logic            JumpE;
  logic            PCSrcE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCTargetE;
  logic            PredTakenF;
  logic [XLEN-1:0] PredPCF;
  logic            BranchPredicted;
  logic            MispredictE;
  logic [XLEN-1:0] RecoverPCE;

  modport master (
    output PCF, StallF, StallD, FlushD, FlushE, BranchE, JumpE, PCSrcE, PCE, PCTargetE,
    input  PredTakenF, PredPCF, BranchPredicted, MispredictE, RecoverPCE
  );

  modport slave (
    input  PCF, StallF, StallD, FlushD, FlushE, BranchE, JumpE, PCSrcE, PCE, PCTargetE,
    output PredTakenF, PredPCF, BranchPredicted, MispredictE, RecoverPCE
  );

endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write,
// valid bits cleared by asynchronous reset (payload is left unreset).
module bpu_btb
  import bpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BTB_IDX_W-1:0] rd_idx,
  output btb_entry_t           rd_entry,
  input  logic                 wr_en,
  input  logic [BTB_IDX_W-1:0] wr_idx,
  input  btb_entry_t           wr_entry
);

  logic [BTB_ENTRIES-1:0] valid_q;
  btb_entry_t             data_q [BTB_ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_entry;
    end
  end

  // Reads see the pre-write contents in the cycle of a write.
  always_comb begin
    rd_entry       = data_q[rd_idx];
    rd_entry.valid = valid_q[rd_idx];
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: BHT + BTB lookup in F, prediction carried to E, resolved there.
// Build macro BPU_GSHARE_EN: XOR global history into the BHT index (default: bimodal).
module branch_predict_unit
  import bpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  branch_predict_unit_if.slave  bus
);

  logic [BHT_IDX_W-1:0] idx_f;
  bht_ctr_e             bht_q [BHT_ENTRIES];
  bht_ctr_e             ctr_f;
  btb_entry_t           btb_rd;
  btb_entry_t           btb_wr;
  logic                 hit_f;
  logic                 pred_taken_f;
  logic [XLEN-1:0]      pc_plus4_f;
  logic [XLEN-1:0]      pred_pc_f;
  bpu_pipe_t            pipe_f;
  bpu_pipe_t            pipe_d;
  bpu_pipe_t            pipe_e;
  logic                 resolve_e;
  logic                 upd_bht;
  logic                 upd_btb;

`ifdef BPU_GSHARE_EN
  logic [GHR_BITS-1:0]  ghr_q;

  assign idx_f = bus.PCF[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);

  // Non-speculative history: only resolved conditional branches shift in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else if (upd_bht) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], bus.PCSrcE};
    end
  end
`else
  assign idx_f = bus.PCF[BHT_IDX_W+1:2];
`endif

  bpu_btb u_btb (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (bus.PCF[BTB_IDX_W+1:2]),
    .rd_entry (btb_rd),
    .wr_en    (upd_btb),
    .wr_idx   (bus.PCE[BTB_IDX_W+1:2]),
    .wr_entry (btb_wr)
  );

  // Fetch-stage prediction.
  assign ctr_f        = bht_q[idx_f];
  assign hit_f        = btb_rd.valid && (btb_rd.tag == bus.PCF[XLEN-1:BTB_IDX_W+2]);
  assign pred_taken_f = hit_f & (btb_rd.is_jump | ctr_f[1]);
  assign pc_plus4_f   = bus.PCF + XLEN'(4);
  assign pred_pc_f    = pred_taken_f ? btb_rd.target : pc_plus4_f;

  assign bus.PredTakenF = pred_taken_f;
  assign bus.PredPCF    = pred_pc_f;

  // A stalled fetch contributes no valid prediction.
  assign pipe_f = '{valid: ~bus.StallF, taken: pred_taken_f, target: pred_pc_f, bht_idx: idx_f};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_d <= '0;
      pipe_e <= '0;
    end else begin
      if (bus.FlushD) begin
        pipe_d <= '0;
      end else if (!bus.StallD) begin
        pipe_d <= pipe_f;
      end
      if (bus.FlushE) begin
        pipe_e <= '0;
      end else begin
        pipe_e <= pipe_d;
      end
    end
  end

  // Execute-stage resolution.
  assign resolve_e = pipe_e.valid & (bus.BranchE | bus.JumpE);
  assign upd_bht   = pipe_e.valid & bus.BranchE;
  assign upd_btb   = pipe_e.valid & ((bus.BranchE & bus.PCSrcE) | bus.JumpE);

  assign bus.BranchPredicted = pipe_e.valid & pipe_e.taken;
  assign bus.RecoverPCE      = bus.PCSrcE ? bus.PCTargetE : (bus.PCE + XLEN'(4));
  assign bus.MispredictE     = resolve_e &
                               ((pipe_e.taken != bus.PCSrcE) |
                                (pipe_e.taken & bus.PCSrcE & (pipe_e.target != bus.PCTargetE)));

  assign btb_wr = '{valid:   1'b1,
                    tag:     bus.PCE[XLEN-1:BTB_IDX_W+2],
                    target:  bus.PCTargetE,
                    is_jump: bus.JumpE};

  // Counters train at the index carried from fetch, not a recomputed one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= WNT;
      end
    end else if (upd_bht) begin
      bht_q[pipe_e.bht_idx] <= ctr_next(bht_q[pipe_e.bht_idx], bus.PCSrcE);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default bimodal build).
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  branch_predict_unit_if bus ();

  branch_predict_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Present pc in F, let its prediction reach E, then resolve it there.
  task automatic run_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic jump, output logic mis, output logic bp,
                            output logic [31:0] rec, output logic pt_now);
    @(negedge clk);
    bus.PCF = pc; bus.BranchE = 1'b0; bus.JumpE = 1'b0; bus.PCSrcE = 1'b0;
    repeat (2) @(negedge clk);
    bus.BranchE = ~jump; bus.JumpE = jump; bus.PCSrcE = taken;
    bus.PCE = pc; bus.PCTargetE = tgt;
    #1;
    mis = bus.MispredictE; bp = bus.BranchPredicted; rec = bus.RecoverPCE; pt_now = bus.PredTakenF;
    @(negedge clk);
    bus.BranchE = 1'b0; bus.JumpE = 1'b0; bus.PCSrcE = 1'b0;
  endtask

  task automatic test_reset();
    bus.PCF = 32'h100; bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    bus.BranchE = 1'b0; bus.JumpE = 1'b0; bus.PCSrcE = 1'b0; bus.PCE = '0; bus.PCTargetE = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (bus.PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b want 0", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h104) begin errors++; $display("FAIL reset_pred_pc: got %h want 00000104", bus.PredPCF); end
    checks++; if (bus.BranchPredicted !== 1'b0) begin errors++; $display("FAIL reset_branch_predicted: got %0b want 0", bus.BranchPredicted); end
    checks++; if (bus.MispredictE !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", bus.MispredictE); end
  endtask

  task automatic test_taken_branch();
    logic mis, bp, pt; logic [31:0] rec;
    run_branch(32'h100, 1'b1, 32'h80, 1'b0, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL first_taken_mispredict: got %0b want 1", mis); end
    checks++; if (bp !== 1'b0) begin errors++; $display("FAIL first_taken_branch_predicted: got %0b want 0", bp); end
    checks++; if (rec !== 32'h80) begin errors++; $display("FAIL first_taken_recover: got %h want 00000080", rec); end
    #1;
    checks++; if (bus.PredTakenF !== 1'b1) begin errors++; $display("FAIL trained_pred_taken: got %0b want 1", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h80) begin errors++; $display("FAIL trained_pred_pc: got %h want 00000080", bus.PredPCF); end
  endtask

  task automatic test_counter_saturation();
    logic mis, bp, pt; logic [31:0] rec;
    for (int i = 0; i < 4; i++) begin
      run_branch(32'h100, 1'b1, 32'h80, 1'b0, mis, bp, rec, pt);
      checks++; if (mis !== 1'b0) begin errors++; $display("FAIL sat_taken_%0d_mispredict: got %0b want 0", i, mis); end
    end
    run_branch(32'h100, 1'b0, 32'h80, 1'b0, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL first_nt_mispredict: got %0b want 1", mis); end
    checks++; if (rec !== 32'h104) begin errors++; $display("FAIL first_nt_recover: got %h want 00000104", rec); end
    #1;
    checks++; if (bus.PredTakenF !== 1'b1) begin errors++; $display("FAIL after_one_nt_pred_taken: got %0b want 1", bus.PredTakenF); end
    run_branch(32'h100, 1'b0, 32'h80, 1'b0, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL second_nt_mispredict: got %0b want 1", mis); end
    #1;
    checks++; if (bus.PredTakenF !== 1'b0) begin errors++; $display("FAIL after_two_nt_pred_taken: got %0b want 0", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h104) begin errors++; $display("FAIL after_two_nt_pred_pc: got %h want 00000104", bus.PredPCF); end
  endtask

  task automatic test_target_mispredict();
    logic mis, bp, pt; logic [31:0] rec;
    run_branch(32'h100, 1'b1, 32'h80, 1'b0, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL retrain_mispredict: got %0b want 1", mis); end
    run_branch(32'h100, 1'b1, 32'h90, 1'b0, mis, bp, rec, pt);
    checks++; if (bp !== 1'b1) begin errors++; $display("FAIL target_branch_predicted: got %0b want 1", bp); end
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL target_mispredict: got %0b want 1", mis); end
    checks++; if (rec !== 32'h90) begin errors++; $display("FAIL target_recover: got %h want 00000090", rec); end
    #1;
    checks++; if (bus.PredPCF !== 32'h90) begin errors++; $display("FAIL new_target_pred_pc: got %h want 00000090", bus.PredPCF); end
  endtask

  task automatic test_jump_and_tag();
    logic mis, bp, pt; logic [31:0] rec;
    run_branch(32'h204, 1'b1, 32'h300, 1'b1, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL jump_first_mispredict: got %0b want 1", mis); end
    #1;
    checks++; if (bus.PredTakenF !== 1'b1) begin errors++; $display("FAIL jump_pred_taken: got %0b want 1", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h300) begin errors++; $display("FAIL jump_pred_pc: got %h want 00000300", bus.PredPCF); end
    bus.PCF = 32'h140;
    #1;
    checks++; if (bus.PredTakenF !== 1'b0) begin errors++; $display("FAIL tag_miss_pred_taken: got %0b want 0", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h144) begin errors++; $display("FAIL tag_miss_pred_pc: got %h want 00000144", bus.PredPCF); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    bus.PCF = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.BranchPredicted !== 1'b1) begin errors++; $display("FAIL fill_branch_predicted: got %0b want 1", bus.BranchPredicted); end
    bus.StallD = 1'b1; bus.FlushE = 1'b1; bus.PCF = 32'h300;
    @(negedge clk);
    bus.StallD = 1'b0; bus.FlushE = 1'b0;
    bus.JumpE = 1'b1; bus.PCSrcE = 1'b1; bus.PCE = 32'h100; bus.PCTargetE = 32'h500;
    #1;
    checks++; if (bus.BranchPredicted !== 1'b0) begin errors++; $display("FAIL flushe_branch_predicted: got %0b want 0", bus.BranchPredicted); end
    checks++; if (bus.MispredictE !== 1'b0) begin errors++; $display("FAIL flushe_mispredict: got %0b want 0", bus.MispredictE); end
    @(negedge clk);
    bus.JumpE = 1'b0; bus.PCSrcE = 1'b0;
    #1;
    checks++; if (bus.BranchPredicted !== 1'b1) begin errors++; $display("FAIL stalld_held_branch_predicted: got %0b want 1", bus.BranchPredicted); end
    bus.PCF = 32'h100;
    #1;
    checks++; if (bus.PredPCF !== 32'h90) begin errors++; $display("FAIL flushed_slot_no_update: got %h want 00000090", bus.PredPCF); end
  endtask

  task automatic test_flushd_priority();
    @(negedge clk);
    bus.PCF = 32'h100;
    repeat (2) @(negedge clk);
    bus.StallD = 1'b1; bus.FlushD = 1'b1;
    @(negedge clk);
    bus.StallD = 1'b0; bus.FlushD = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.BranchPredicted !== 1'b0) begin errors++; $display("FAIL flushd_over_stalld: got %0b want 0", bus.BranchPredicted); end
  endtask

  task automatic test_same_cycle();
    logic mis, bp, pt; logic [31:0] rec;
    run_branch(32'h108, 1'b1, 32'h400, 1'b0, mis, bp, rec, pt);
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL same_cycle_old_pred: got %0b want 0", pt); end
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL same_cycle_mispredict: got %0b want 1", mis); end
    #1;
    checks++; if (bus.PredTakenF !== 1'b1) begin errors++; $display("FAIL next_cycle_new_pred: got %0b want 1", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h400) begin errors++; $display("FAIL next_cycle_new_pc: got %h want 00000400", bus.PredPCF); end
  endtask

  task automatic test_async_reset();
    logic mis, bp, pt; logic [31:0] rec;
    @(negedge clk);
    bus.PCF = 32'h100;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.PredTakenF !== 1'b0) begin errors++; $display("FAIL midrun_reset_pred_taken: got %0b want 0", bus.PredTakenF); end
    checks++; if (bus.PredPCF !== 32'h104) begin errors++; $display("FAIL midrun_reset_pred_pc: got %h want 00000104", bus.PredPCF); end
    checks++; if (bus.BranchPredicted !== 1'b0) begin errors++; $display("FAIL midrun_reset_branch_predicted: got %0b want 0", bus.BranchPredicted); end
    @(negedge clk);
    reset_n = 1'b1;
    run_branch(32'h100, 1'b1, 32'h80, 1'b0, mis, bp, rec, pt);
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL post_reset_btb_cold: got %0b want 1", mis); end
    run_branch(32'h100, 1'b0, 32'h80, 1'b0, mis, bp, rec, pt);
    #1;
    checks++; if (bus.PredTakenF !== 1'b0) begin errors++; $display("FAIL post_reset_counter_wnt: got %0b want 0", bus.PredTakenF); end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_counter_saturation();
    test_target_mispredict();
    test_jump_and_tag();
    test_stall_flush();
    test_flushd_priority();
    test_same_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
